// File: rtl/dist_sq.sv
// Squared Euclidean distance between two 2-D points, computed with an iterative shift-add
// multiplier and saturated to OUT_W bits for the downstream integer square-root stage.
module dist_sq #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned OUT_W   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   dsq,
  output logic               sat
);

  localparam int unsigned ACC_W = 2 * COORD_W + 1;
  localparam int unsigned CNT_W = $clog2(COORD_W + 1);
  localparam logic [ACC_W-1:0] MAX_OUT = ACC_W'({OUT_W{1'b1}});

  typedef enum logic [1:0] {StIdle, StMulX, StMulY, StDone} state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   dsq_q, dsq_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [COORD_W-1:0] opnd;
  logic               bit_on;
  logic [ACC_W-1:0]   addend;

  assign opnd   = (state_q == StMulY) ? dy_q : dx_q;
  // Shifting a one past the top bit yields zero, so cnt == COORD_W never adds.
  assign bit_on = |(opnd & (COORD_W'(1) << cnt_q));
  assign addend = ACC_W'(opnd) << cnt_q;

  always_comb begin
    state_d     = state_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dsq_d       = dsq_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          dx_d    = (x1 >= x2) ? x1 - x2 : x2 - x1;
          dy_d    = (y1 >= y2) ? y1 - y2 : y2 - y1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StMulX;
        end
      end
      StMulX: begin
        if (bit_on) acc_d = acc_q + addend;
        if (cnt_q == CNT_W'(COORD_W - 1)) begin
          cnt_d   = '0;
          state_d = StMulY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StMulY: begin
        // The extra cnt == COORD_W cycle saturates the finished sum, keeping the
        // adder and the comparator out of the same path.
        if (cnt_q == CNT_W'(COORD_W)) begin
          sat_d       = (acc_q > MAX_OUT);
          dsq_d       = (acc_q > MAX_OUT) ? '1 : acc_q[OUT_W-1:0];
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = StDone;
        end else begin
          if (bit_on) acc_d = acc_q + addend;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    in_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      dx_q        <= '0;
      dy_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      dsq_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dsq_q       <= dsq_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dsq       = dsq_q;
  assign sat       = sat_q;

endmodule
